// File: rtl/dbg_uart_bridge_if.sv
// Host byte link and register-bus control signals of dbg_uart_bridge.
// MB_Data is bidirectional and stays a plain inout port on the bridge itself.
interface dbg_uart_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        Read_Reg;
  logic        Write_Reg;
  logic [15:0] MB_Addr;
  logic        busy;
  logic        overrun;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, Read_Reg, Write_Reg, MB_Addr, busy, overrun
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, Read_Reg, Write_Reg, MB_Addr, busy, overrun
  );
endinterface

// File: rtl/dbg_uart_bridge.sv
// Host byte-frame to debug register bus bridge (write 0x57, read 0x52, else 0x3F).
// Define DBG_UART_BRIDGE_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES.
module dbg_uart_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              Reset,
  dbg_uart_bridge_if.master bus,
  inout  wire  [15:0]       MB_Data
);
  localparam logic [7:0]  CmdWrite    = 8'h57;
  localparam logic [7:0]  CmdRead     = 8'h52;
  localparam logic [7:0]  RspAck      = 8'h4B;
  localparam logic [7:0]  RspUnknown  = 8'h3F;
  localparam logic [23:0] TimeoutLast = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, BUS_WR, BUS_RD, TX_B0, TX_B1
  } state_e;

  state_e      state_q;
  logic        isWrite_q;
  logic [7:0]  addrHi_q;
  logic [7:0]  dataHi_q;
  logic [7:0]  rdLo_q;
  logic [7:0]  txData_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        txValid_q;
  logic        rdStrobe_q;
  logic        wrStrobe_q;
  logic        busy_q;
  logic        overrun_q;
  logic        collecting;
  logic        expire;

  assign collecting = state_q inside {ADDR_H, ADDR_L, DATA_H, DATA_L};

`ifdef DBG_UART_BRIDGE_TIMEOUT_EN
  logic [23:0] idleCnt_q;

  // A byte arriving in the expiry cycle wins, so expiry requires a silent cycle.
  assign expire = collecting && !bus.rx_valid && (idleCnt_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (Reset || !collecting || bus.rx_valid || expire) idleCnt_q <= '0;
    else                                                 idleCnt_q <= idleCnt_q + 24'd1;
  end
`else
  logic unusedTimeoutLast;
  assign unusedTimeoutLast = ^TimeoutLast;
  assign expire            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      isWrite_q  <= 1'b0;
      addrHi_q   <= '0;
      dataHi_q   <= '0;
      rdLo_q     <= '0;
      txData_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      txValid_q  <= 1'b0;
      rdStrobe_q <= 1'b0;
      wrStrobe_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rdStrobe_q <= 1'b0;
      wrStrobe_q <= 1'b0;
      if (bus.rx_valid && (state_q inside {BUS_WR, BUS_RD, TX_B0, TX_B1}))
        overrun_q <= 1'b1;
      if (expire) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.rx_valid) begin
            busy_q <= 1'b1;
            if (bus.rx_data == CmdWrite || bus.rx_data == CmdRead) begin
              isWrite_q <= (bus.rx_data == CmdWrite);
              state_q   <= ADDR_H;
            end else begin
              txData_q  <= RspUnknown;
              txValid_q <= 1'b1;
              state_q   <= TX_B1;
            end
          end
          ADDR_H: if (bus.rx_valid) begin
            addrHi_q <= bus.rx_data;
            state_q  <= ADDR_L;
          end
          ADDR_L: if (bus.rx_valid) begin
            addr_q <= {addrHi_q, bus.rx_data};
            if (isWrite_q) begin
              state_q <= DATA_H;
            end else begin
              rdStrobe_q <= 1'b1;
              state_q    <= BUS_RD;
            end
          end
          DATA_H: if (bus.rx_valid) begin
            dataHi_q <= bus.rx_data;
            state_q  <= DATA_L;
          end
          DATA_L: if (bus.rx_valid) begin
            wdata_q    <= {dataHi_q, bus.rx_data};
            wrStrobe_q <= 1'b1;
            state_q    <= BUS_WR;
          end
          BUS_WR: begin
            txData_q  <= RspAck;
            txValid_q <= 1'b1;
            state_q   <= TX_B1;
          end
          // The register block answers combinationally while Read_Reg is high.
          BUS_RD: begin
            txData_q  <= MB_Data[15:8];
            rdLo_q    <= MB_Data[7:0];
            txValid_q <= 1'b1;
            state_q   <= TX_B0;
          end
          TX_B0: if (bus.tx_ready) begin
            txData_q <= rdLo_q;
            state_q  <= TX_B1;
          end
          TX_B1: if (bus.tx_ready) begin
            txValid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
          default: begin
            txValid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_data   = txData_q;
  assign bus.tx_valid  = txValid_q;
  assign bus.Read_Reg  = rdStrobe_q;
  assign bus.Write_Reg = wrStrobe_q;
  assign bus.MB_Addr   = addr_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign MB_Data       = wrStrobe_q ? wdata_q : 16'bz;
endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Self-checking bench for dbg_uart_bridge: vector table, directed corner cases,
// and randomized frames checked against a frame-level reference model.
module tb_dbg_uart_bridge;
  localparam int unsigned TimeoutCycles = 16;

  logic clk = 1'b0;
  logic Reset;
  wire [15:0] MB_Data;

  dbg_uart_bridge_if busIf();

  dbg_uart_bridge #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .bus     (busIf),
    .MB_Data (MB_Data)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nFailed   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Register-block model: unwritten addresses return a fixed pattern.
  function automatic logic [15:0] defaultData(input logic [15:0] a);
    return (a == 16'hFF07) ? 16'h55AA : (a ^ 16'hA5C3);
  endfunction

  logic [15:0]  slaveMem [256];
  logic [255:0] slaveHas = '0;
  logic [15:0]  slaveRdata;

  always_comb begin
    slaveRdata = defaultData(busIf.MB_Addr);
    if (busIf.MB_Addr[15:8] == 8'hC0 && slaveHas[busIf.MB_Addr[7:0]])
      slaveRdata = slaveMem[busIf.MB_Addr[7:0]];
  end

  assign MB_Data = busIf.Read_Reg ? slaveRdata : 16'bz;

  always @(posedge clk) begin
    if (busIf.Write_Reg && busIf.MB_Addr[15:8] == 8'hC0) begin
      slaveMem[busIf.MB_Addr[7:0]] <= MB_Data;
      slaveHas[busIf.MB_Addr[7:0]] <= 1'b1;
    end
  end

  // Transmit-side ready: 0 = always ready, 1 = random, 2 = stalled.
  int readyMode = 0;
  initial begin
    busIf.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (readyMode)
        0:       busIf.tx_ready = 1'b1;
        1:       busIf.tx_ready = ($urandom_range(0, 3) != 0);
        default: busIf.tx_ready = 1'b0;
      endcase
    end
  end

  logic [7:0]  txQ [$];
  logic [31:0] wrQ [$];
  int          rdPulses  = 0;
  logic        prevStrobe = 1'b0;
  logic        prevStall  = 1'b0;
  logic [7:0]  prevTx     = 8'h00;

  always @(negedge clk) begin
    #1;
    if (busIf.tx_valid && busIf.tx_ready) txQ.push_back(busIf.tx_data);
    if (busIf.Write_Reg) wrQ.push_back({busIf.MB_Addr, MB_Data});
    if (busIf.Read_Reg) rdPulses++;
    if (busIf.Read_Reg || busIf.Write_Reg) begin
      checkOutput("strobe_exclusive", {31'b0, busIf.Read_Reg & busIf.Write_Reg}, 32'd0);
      checkOutput("strobe_single_cycle", {31'b0, prevStrobe}, 32'd0);
    end
    if (prevStall) begin
      checkOutput("tx_hold_valid", {31'b0, busIf.tx_valid}, 32'd1);
      checkOutput("tx_hold_data", {24'b0, busIf.tx_data}, {24'b0, prevTx});
    end
    prevStrobe = busIf.Read_Reg | busIf.Write_Reg;
    prevStall  = busIf.tx_valid && !busIf.tx_ready && !Reset;
    prevTx     = busIf.tx_data;
  end

  // Frame-level reference model: memory contents and the last bus address.
  logic [15:0] refMem [logic [15:0]];
  logic [15:0] modelAddr = 16'h0000;

  task automatic modelFrame(input logic [39:0] f, output logic [7:0] e0, output logic [7:0] e1,
                            output int eTxLen, output int eWr, output logic [31:0] eWrWord,
                            output int eRd, output logic [15:0] eAddr);
    logic [15:0] a;
    logic [15:0] d;
    a = f[31:16];
    d = f[15:0];
    e0 = 8'h00; e1 = 8'h00; eWr = 0; eRd = 0; eWrWord = 32'h0;
    if (f[39:32] == 8'h57) begin
      refMem[a] = d;
      e0 = 8'h4B; eTxLen = 1; eWr = 1; eWrWord = {a, d};
      modelAddr = a;
    end else if (f[39:32] == 8'h52) begin
      d = refMem.exists(a) ? refMem[a] : defaultData(a);
      e0 = d[15:8]; e1 = d[7:0]; eTxLen = 2; eRd = 1;
      modelAddr = a;
    end else begin
      e0 = 8'h3F; eTxLen = 1;
    end
    eAddr = modelAddr;
  endtask

  task automatic applyStimulus(input logic [39:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      busIf.rx_data  = f[39-8*i -: 8];
      busIf.rx_valid = 1'b1;
    end
    @(negedge clk);
    busIf.rx_valid = 1'b0;
  endtask

  task automatic waitTx(input int n, input int budget, input string name);
    int k = 0;
    while (txQ.size() < n && k < budget) begin
      @(negedge clk); #2; k++;
    end
    if (txQ.size() < n) checkOutput(name, txQ.size(), n);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int k = 0;
    while (busIf.busy && k < budget) begin
      @(negedge clk); #2; k++;
    end
    if (busIf.busy) checkOutput(name, 32'd1, 32'd0);
  endtask

  task automatic runFrame(input logic [39:0] f, input int len, input logic [7:0] e0, input logic [7:0] e1,
                          input int eTxLen, input int eWr, input logic [31:0] eWrWord,
                          input int eRd, input logic [15:0] eAddr, input string tag);
    int rd0;
    txQ.delete();
    wrQ.delete();
    rd0 = rdPulses;
    applyStimulus(f, len);
    waitTx(eTxLen, 300, {tag, "_tx_timeout"});
    waitIdle(50, {tag, "_idle_timeout"});
    repeat (2) @(negedge clk);
    #2;
    checkOutput({tag, "_txcount"}, txQ.size(), eTxLen);
    if (txQ.size() > 0) checkOutput({tag, "_tx0"}, {24'b0, txQ[0]}, {24'b0, e0});
    if (eTxLen > 1 && txQ.size() > 1) checkOutput({tag, "_tx1"}, {24'b0, txQ[1]}, {24'b0, e1});
    checkOutput({tag, "_wrcount"}, wrQ.size(), eWr);
    if (eWr > 0 && wrQ.size() > 0) checkOutput({tag, "_wrop"}, wrQ[0], eWrWord);
    checkOutput({tag, "_rdcount"}, rdPulses - rd0, eRd);
    checkOutput({tag, "_addr"}, {16'b0, busIf.MB_Addr}, {16'b0, eAddr});
    checkOutput({tag, "_busy"}, {31'b0, busIf.busy}, 32'd0);
  endtask

  typedef struct {
    logic [39:0] bytes;
    int          len;
    logic [7:0]  e0;
    logic [7:0]  e1;
    int          txLen;
    int          nWr;
    logic [31:0] wrWord;
    int          nRd;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs [7];

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tx_valid"}, {31'b0, busIf.tx_valid}, 32'd0);
    checkOutput({tag, "_tx_data"}, {24'b0, busIf.tx_data}, 32'd0);
    checkOutput({tag, "_read_reg"}, {31'b0, busIf.Read_Reg}, 32'd0);
    checkOutput({tag, "_write_reg"}, {31'b0, busIf.Write_Reg}, 32'd0);
    checkOutput({tag, "_mb_addr"}, {16'b0, busIf.MB_Addr}, 32'd0);
    checkOutput({tag, "_busy"}, {31'b0, busIf.busy}, 32'd0);
    checkOutput({tag, "_overrun"}, {31'b0, busIf.overrun}, 32'd0);
  endtask

  initial begin
    logic [7:0]  e0, e1;
    logic [31:0] eWrWord;
    logic [15:0] eAddr;
    logic [39:0] f;
    int          eTxLen, eWr, eRd, k;

    vecs[0] = '{40'h57FFFF0006, 5, 8'h4B, 8'h00, 1, 1, 32'hFFFF0006, 0, 16'hFFFF};
    vecs[1] = '{40'h52FF070000, 3, 8'h55, 8'hAA, 2, 0, 32'h0, 1, 16'hFF07};
    vecs[2] = '{40'h4100000000, 1, 8'h3F, 8'h00, 1, 0, 32'h0, 0, 16'hFF07};
    vecs[3] = '{40'h57C0101234, 5, 8'h4B, 8'h00, 1, 1, 32'hC0101234, 0, 16'hC010};
    vecs[4] = '{40'h52C0100000, 3, 8'h12, 8'h34, 2, 0, 32'h0, 1, 16'hC010};
    vecs[5] = '{40'h5200010000, 3, 8'hA5, 8'hC2, 2, 0, 32'h0, 1, 16'h0001};
    vecs[6] = '{40'hFF00000000, 1, 8'h3F, 8'h00, 1, 0, 32'h0, 0, 16'h0001};

    busIf.rx_data  = 8'h00;
    busIf.rx_valid = 1'b0;
    Reset          = 1'b1;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    #2;
    checkResetValues("reset");

    for (int i = 0; i < 7; i++) begin
      modelFrame(vecs[i].bytes, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr);
      runFrame(vecs[i].bytes, vecs[i].len, vecs[i].e0, vecs[i].e1, vecs[i].txLen,
               vecs[i].nWr, vecs[i].wrWord, vecs[i].nRd, vecs[i].addr, $sformatf("vec%0d", i));
    end

    // Backpressure on the two-byte read response.
    readyMode = 2;
    txQ.delete();
    applyStimulus(40'h52FF070000, 3);
    k = 0;
    while (!busIf.tx_valid && k < 20) begin
      @(negedge clk); #2; k++;
    end
    checkOutput("bp_valid", {31'b0, busIf.tx_valid}, 32'd1);
    repeat (10) begin
      @(negedge clk); #2;
      checkOutput("bp_data", {24'b0, busIf.tx_data}, 32'h55);
    end
    checkOutput("bp_no_early_byte", txQ.size(), 32'd0);
    readyMode = 0;
    waitTx(2, 50, "bp_tx_timeout");
    if (txQ.size() > 1) begin
      checkOutput("bp_tx0", {24'b0, txQ[0]}, 32'h55);
      checkOutput("bp_tx1", {24'b0, txQ[1]}, 32'hAA);
    end
    waitIdle(20, "bp_idle_timeout");
    modelFrame(40'h52FF070000, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr);

    // Unknown command, then a byte during its response sets overrun.
    readyMode = 2;
    txQ.delete();
    applyStimulus(40'h4100000000, 1);
    repeat (2) @(negedge clk);
    #2;
    checkOutput("unk_tx_valid", {31'b0, busIf.tx_valid}, 32'd1);
    checkOutput("unk_tx_data", {24'b0, busIf.tx_data}, 32'h3F);
    checkOutput("unk_overrun_before", {31'b0, busIf.overrun}, 32'd0);
    applyStimulus(40'h3100000000, 1);
    #2;
    checkOutput("unk_overrun_set", {31'b0, busIf.overrun}, 32'd1);
    readyMode = 0;
    waitTx(1, 20, "unk_tx_timeout");
    waitIdle(20, "unk_idle_timeout");
    repeat (3) @(negedge clk);
    #2;
    checkOutput("unk_tx_count", txQ.size(), 32'd1);
    if (txQ.size() > 0) checkOutput("unk_tx0", {24'b0, txQ[0]}, 32'h3F);
    checkOutput("unk_busy_after", {31'b0, busIf.busy}, 32'd0);
    modelFrame(40'h4100000000, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr);
    modelFrame(40'h52C0100000, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr);
    runFrame(40'h52C0100000, 3, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr, "after_overrun");
    checkOutput("overrun_sticky", {31'b0, busIf.overrun}, 32'd1);

    // Reset in the middle of a write frame.
    wrQ.delete();
    applyStimulus(40'h57FFFF0000, 4);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    #2;
    checkResetValues("midreset");
    repeat (4) @(negedge clk);
    #2;
    checkOutput("midreset_no_write", wrQ.size(), 32'd0);
    modelAddr = 16'h0000;
    modelFrame(40'h57C020BEEF, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr);
    runFrame(40'h57C020BEEF, 5, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr, "after_reset");

    // Stalled frame: aborted by the timeout when enabled, otherwise held open.
    applyStimulus(40'h5712000000, 2);
`ifdef DBG_UART_BRIDGE_TIMEOUT_EN
    repeat (15) @(negedge clk);
    #2;
    checkOutput("timeout_not_yet", {31'b0, busIf.busy}, 32'd1);
    @(negedge clk);
    #2;
    checkOutput("timeout_idle", {31'b0, busIf.busy}, 32'd0);
    modelFrame(40'h5200010000, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr);
    runFrame(40'h5200010000, 3, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr, "after_timeout");
`else
    repeat (40) @(negedge clk);
    #2;
    checkOutput("no_timeout_busy", {31'b0, busIf.busy}, 32'd1);
    modelFrame(40'h5712340007, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr);
    runFrame(40'h3400070000, 3, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr, "stall_resume");
`endif

    // Randomized frames with random transmit backpressure.
    readyMode = 1;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      f = {8'h00, 8'hC0, 4'h0, 4'($urandom_range(0, 15)), 16'($urandom)};
      if (k < 2) begin
        f[39:32] = 8'($urandom_range(0, 255));
        if (f[39:32] == 8'h57 || f[39:32] == 8'h52) f[39:32] = 8'h00;
      end else if (k < 6) begin
        f[39:32] = 8'h57;
      end else begin
        f[39:32] = 8'h52;
      end
      modelFrame(f, e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr);
      runFrame(f, (k < 2) ? 1 : ((k < 6) ? 5 : 3), e0, e1, eTxLen, eWr, eWrWord, eRd, eAddr,
               $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
